// File: rtl/merlin_port_arbiter_pkg.sv
// Shared definitions for the merlin instruction/data port arbiter.
// Source tags identify which core port owns an outstanding transaction.
// Instruction requests always move a full word.
package merlin_port_arbiter_pkg;

  localparam int unsigned RV_XLEN = 32;

  // Owner of a memory transaction, as recorded in the source FIFO
  typedef enum logic {
    SRC_INS = 1'b0,
    SRC_DAT = 1'b1
  } src_e;

  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/merlin_src_fifo.sv
// In-order 1-bit tag FIFO recording the originator of each outstanding request.
// Latency: push visible at head one cycle later; head/full/empty are registered state.
// Backpressure: pushes while full and pops while empty are ignored; clk_en_i=0 freezes state.
module merlin_src_fifo #(
  parameter int unsigned DEPTH_X = 2
) (
  input  logic clk_i,
  input  logic clk_en_i,
  input  logic resetb_i,
  input  logic push_i,
  input  logic push_dat_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_X;
  localparam logic [DEPTH_X:0] DEPTH_CNT = DEPTH[DEPTH_X:0];

  logic [DEPTH-1:0]   mem_q, mem_d;
  logic [DEPTH_X-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_X-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_X:0]   cnt_q, cnt_d;
  logic               push_ok, pop_ok;

  assign full_o  = (cnt_q == DEPTH_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = clk_en_i & push_i & ~full_o;
  assign pop_ok  = clk_en_i & pop_i & ~empty_o;

  // Next-state: write at wr_ptr, advance pointers, track occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers, cleared to empty by the asynchronous reset
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/merlin_port_arbiter.sv
// Merges instruction and data request ports onto one memory port; routes in-order responses back.
// Latency: zero on both request and response paths (combinational muxing).
// Backpressure: stalled request keeps its grant; full source FIFO blocks new requests. Build option MERLIN_ARB_RR_EN selects round-robin.
module merlin_port_arbiter
  import merlin_port_arbiter_pkg::*;
#(
  parameter int unsigned C_OTX_DEPTH_X = 2
) (
  input  logic               clk_i,
  input  logic               clk_en_i,
  input  logic               resetb_i,
  // instruction request
  output logic               ireqready_o,
  input  logic               ireqvalid_i,
  input  logic [1:0]         ireqhpl_i,
  input  logic [RV_XLEN-1:0] ireqaddr_i,
  // instruction response
  input  logic               irspready_i,
  output logic               irspvalid_o,
  output logic               irsprerr_o,
  output logic [RV_XLEN-1:0] irspdata_o,
  // data request
  output logic               dreqready_o,
  input  logic               dreqvalid_i,
  input  logic [1:0]         dreqsize_i,
  input  logic               dreqdvalid_i,
  input  logic [1:0]         dreqhpl_i,
  input  logic [RV_XLEN-1:0] dreqaddr_i,
  input  logic [RV_XLEN-1:0] dreqdata_i,
  // data response
  input  logic               drspready_i,
  output logic               drspvalid_o,
  output logic               drsprerr_o,
  output logic               drspwerr_o,
  output logic [RV_XLEN-1:0] drspdata_o,
  // shared memory request
  input  logic               mreqready_i,
  output logic               mreqvalid_o,
  output logic [1:0]         mreqsize_o,
  output logic               mreqdvalid_o,
  output logic [1:0]         mreqhpl_o,
  output logic [RV_XLEN-1:0] mreqaddr_o,
  output logic [RV_XLEN-1:0] mreqdata_o,
  // shared memory response
  output logic               mrspready_o,
  input  logic               mrspvalid_i,
  input  logic               mrsprerr_i,
  input  logic               mrspwerr_i,
  input  logic [RV_XLEN-1:0] mrspdata_i
);

  logic lock_q, lock_d;
  src_e lock_src_q, lock_src_d;
  src_e arb_src;
  src_e gnt;
  logic sel_vld;
  logic fifo_full, fifo_empty, fifo_head;
  logic req_xfer, rsp_xfer;

`ifdef MERLIN_ARB_RR_EN
  src_e last_q, last_d;
`endif

  // Free arbitration between the two request ports (only used when no grant is locked)
  always_comb begin
    arb_src = SRC_INS;
    if (ireqvalid_i && dreqvalid_i) begin
`ifdef MERLIN_ARB_RR_EN
      arb_src = (last_q == SRC_INS) ? SRC_DAT : SRC_INS;
`else
      arb_src = SRC_DAT;
`endif
    end else if (dreqvalid_i) begin
      arb_src = SRC_DAT;
    end
  end

  assign gnt      = lock_q ? lock_src_q : arb_src;
  assign sel_vld  = (gnt == SRC_DAT) ? dreqvalid_i : ireqvalid_i;
  assign req_xfer = clk_en_i & mreqvalid_o & mreqready_i;
  assign rsp_xfer = clk_en_i & mrspvalid_i & mrspready_o;

  // A full FIFO blocks the request even when a response pops in the same cycle
  assign mreqvalid_o = sel_vld & ~fifo_full;
  assign ireqready_o = (gnt == SRC_INS) & ireqvalid_i & mreqready_i & ~fifo_full;
  assign dreqready_o = (gnt == SRC_DAT) & dreqvalid_i & mreqready_i & ~fifo_full;

  // Request payload mux; instruction fetches are word-sized reads with no write data
  always_comb begin
    mreqaddr_o   = ireqaddr_i;
    mreqhpl_o    = ireqhpl_i;
    mreqsize_o   = SIZE_WORD;
    mreqdvalid_o = 1'b0;
    mreqdata_o   = '0;
    if (gnt == SRC_DAT) begin
      mreqaddr_o   = dreqaddr_i;
      mreqhpl_o    = dreqhpl_i;
      mreqsize_o   = dreqsize_i;
      mreqdvalid_o = dreqvalid_i ? dreqdvalid_i : 1'b0;
      mreqdata_o   = dreqdata_i;
    end
  end

  // Grant lock: a presented but unaccepted request keeps the grant until it transfers
  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (clk_en_i) begin
      lock_d     = mreqvalid_o & ~mreqready_i;
      lock_src_d = gnt;
    end
  end

`ifdef MERLIN_ARB_RR_EN
  // Round-robin history: remember the owner of the last accepted request
  always_comb begin
    last_d = last_q;
    if (req_xfer) begin
      last_d = gnt;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      last_q <= SRC_INS;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Grant lock registers
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INS;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
    end
  end

  merlin_src_fifo #(
    .DEPTH_X (C_OTX_DEPTH_X)
  ) u_src_fifo (
    .clk_i      (clk_i),
    .clk_en_i   (clk_en_i),
    .resetb_i   (resetb_i),
    .push_i     (req_xfer),
    .push_dat_i (gnt),
    .pop_i      (rsp_xfer),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head)
  );

  // Response routing: the FIFO head names the port that owns the returning response
  always_comb begin
    irspvalid_o = 1'b0;
    drspvalid_o = 1'b0;
    mrspready_o = 1'b0;
    if (!fifo_empty) begin
      if (fifo_head == SRC_DAT) begin
        drspvalid_o = mrspvalid_i;
        mrspready_o = drspready_i;
      end else begin
        irspvalid_o = mrspvalid_i;
        mrspready_o = irspready_i;
      end
    end
  end

  assign irspdata_o = mrspdata_i;
  assign irsprerr_o = mrsprerr_i;
  assign drspdata_o = mrspdata_i;
  assign drsprerr_o = mrsprerr_i;
  assign drspwerr_o = mrspwerr_i;

endmodule

// File: tb/tb_merlin_port_arbiter.sv
// Self-checking bench for merlin_port_arbiter: vector table, directed corner sequences, random vs model.
// Outputs are sampled 2 time units after each rising edge; inputs change 1 unit after it.
// Honours MERLIN_ARB_RR_EN to select the expected arbitration policy.
module tb_merlin_port_arbiter;

`ifdef MERLIN_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [31:0] IA = 32'h0000_0100;
  localparam logic [31:0] DA = 32'h0000_0200;
  localparam logic [31:0] DD = 32'hD0D0_0001;
  localparam int NRAND = 3000;

  logic        clk_i = 1'b0;
  logic        clk_en_i, resetb_i;
  logic        ireqready_o, ireqvalid_i;
  logic [1:0]  ireqhpl_i;
  logic [31:0] ireqaddr_i;
  logic        irspready_i, irspvalid_o, irsprerr_o;
  logic [31:0] irspdata_o;
  logic        dreqready_o, dreqvalid_i, dreqdvalid_i;
  logic [1:0]  dreqsize_i, dreqhpl_i;
  logic [31:0] dreqaddr_i, dreqdata_i;
  logic        drspready_i, drspvalid_o, drsprerr_o, drspwerr_o;
  logic [31:0] drspdata_o;
  logic        mreqready_i, mreqvalid_o, mreqdvalid_o;
  logic [1:0]  mreqsize_o, mreqhpl_o;
  logic [31:0] mreqaddr_o, mreqdata_o;
  logic        mrspready_o, mrspvalid_i, mrsprerr_i, mrspwerr_i;
  logic [31:0] mrspdata_i;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  merlin_port_arbiter #(.C_OTX_DEPTH_X(2)) dut (
    .clk_i(clk_i), .clk_en_i(clk_en_i), .resetb_i(resetb_i),
    .ireqready_o(ireqready_o), .ireqvalid_i(ireqvalid_i), .ireqhpl_i(ireqhpl_i), .ireqaddr_i(ireqaddr_i),
    .irspready_i(irspready_i), .irspvalid_o(irspvalid_o), .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o),
    .dreqready_o(dreqready_o), .dreqvalid_i(dreqvalid_i), .dreqsize_i(dreqsize_i), .dreqdvalid_i(dreqdvalid_i),
    .dreqhpl_i(dreqhpl_i), .dreqaddr_i(dreqaddr_i), .dreqdata_i(dreqdata_i),
    .drspready_i(drspready_i), .drspvalid_o(drspvalid_o), .drsprerr_o(drsprerr_o), .drspwerr_o(drspwerr_o),
    .drspdata_o(drspdata_o),
    .mreqready_i(mreqready_i), .mreqvalid_o(mreqvalid_o), .mreqsize_o(mreqsize_o), .mreqdvalid_o(mreqdvalid_o),
    .mreqhpl_o(mreqhpl_o), .mreqaddr_o(mreqaddr_o), .mreqdata_o(mreqdata_o),
    .mrspready_o(mrspready_o), .mrspvalid_i(mrspvalid_i), .mrsprerr_i(mrsprerr_i), .mrspwerr_i(mrspwerr_i),
    .mrspdata_i(mrspdata_i)
  );

  // A response presented while nothing is outstanding is a bench protocol error
  always @(negedge clk_i) begin
    if (resetb_i && mrspvalid_i) begin
      assert (irspvalid_o || drspvalid_o)
        else $error("protocol: response presented with no outstanding request");
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic        iv, dv, mr;
    logic        ev, eir, edr;
    logic [31:0] eaddr;
    logic [1:0]  esize;
    logic        edv;
    logic [31:0] edata;
  } vec_t;

  vec_t tbl[6];

  // model state for the random phase
  bit   q[$];
  bit   last_src, hold, hold_src;

  initial begin
    clk_en_i = 1'b0; resetb_i = 1'b0;
    ireqvalid_i = 1'b0; ireqhpl_i = 2'b01; ireqaddr_i = IA;
    dreqvalid_i = 1'b0; dreqsize_i = 2'b01; dreqdvalid_i = 1'b1; dreqhpl_i = 2'b10;
    dreqaddr_i = DA; dreqdata_i = DD;
    irspready_i = 1'b0; drspready_i = 1'b0; mreqready_i = 1'b0;
    mrspvalid_i = 1'b0; mrsprerr_i = 1'b0; mrspwerr_i = 1'b0; mrspdata_i = '0;

    // ---------------- reset state
    #3;
    chk("rst_mreqvalid", mreqvalid_o, 0);
    chk("rst_irspvalid", irspvalid_o, 0);
    chk("rst_drspvalid", drspvalid_o, 0);
    chk("rst_mrspready", mrspready_o, 0);
    chk("rst_ireqready", ireqready_o, 0);
    chk("rst_dreqready", dreqready_o, 0);
    tick(); tick();
    resetb_i = 1'b1;

    // ---------------- combinational vector table (clk_en_i=0 keeps state frozen)
    //            iv  dv  mr   ev  eir edr  addr  size   dvld  data
    tbl[0] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 32'h0, 2'b00, 1'b0, 32'h0};
    tbl[1] = '{1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0, IA,    2'b10, 1'b0, 32'h0};
    tbl[2] = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0, IA,    2'b10, 1'b0, 32'h0};
    tbl[3] = '{1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1, DA,    2'b01, 1'b1, DD};
    tbl[4] = '{1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1, DA,    2'b01, 1'b1, DD};
    tbl[5] = '{1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0, DA,    2'b01, 1'b1, DD};
    for (int i = 0; i < 6; i++) begin
      ireqvalid_i = tbl[i].iv; dreqvalid_i = tbl[i].dv; mreqready_i = tbl[i].mr;
      #1;
      chk($sformatf("vec%0d_mreqvalid", i), mreqvalid_o, tbl[i].ev);
      chk($sformatf("vec%0d_ireqready", i), ireqready_o, tbl[i].eir);
      chk($sformatf("vec%0d_dreqready", i), dreqready_o, tbl[i].edr);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_addr", i), mreqaddr_o, tbl[i].eaddr);
        chk($sformatf("vec%0d_size", i), mreqsize_o, tbl[i].esize);
        chk($sformatf("vec%0d_dvalid", i), mreqdvalid_o, tbl[i].edv);
        chk($sformatf("vec%0d_data", i), mreqdata_o, tbl[i].edata);
      end
    end
    ireqvalid_i = 1'b0; dreqvalid_i = 1'b0; mreqready_i = 1'b0;
    tick();

    // ---------------- both ports valid: data first, then instr; responses routed in order
    clk_en_i = 1'b1; irspready_i = 1'b1; drspready_i = 1'b1;
    ireqvalid_i = 1'b1; dreqvalid_i = 1'b1; mreqready_i = 1'b1;
    #1;
    chk("both_first_addr", mreqaddr_o, DA);
    chk("both_first_ireqready", ireqready_o, 0);
    tick();
    dreqvalid_i = 1'b0;
    #1;
    chk("both_second_addr", mreqaddr_o, IA);
    chk("both_second_ireqready", ireqready_o, 1);
    tick();
    ireqvalid_i = 1'b0;
    mrspvalid_i = 1'b1; mrspdata_i = 32'hDA7A_0000;
    #1;
    chk("rsp0_drspvalid", drspvalid_o, 1);
    chk("rsp0_irspvalid", irspvalid_o, 0);
    chk("rsp0_drspdata", drspdata_o, 32'hDA7A_0000);
    chk("rsp0_mrspready", mrspready_o, 1);
    tick();
    mrspdata_i = 32'h1A5A_0000; mrsprerr_i = 1'b1;
    #1;
    chk("rsp1_irspvalid", irspvalid_o, 1);
    chk("rsp1_drspvalid", drspvalid_o, 0);
    chk("rsp1_irspdata", irspdata_o, 32'h1A5A_0000);
    chk("rsp1_irsprerr", irsprerr_o, 1);
    tick();
    mrspvalid_i = 1'b0; mrsprerr_i = 1'b0;
    #1;
    chk("empty_mrspready", mrspready_o, 0);

    // ---------------- both valid for 4 back-to-back transfers: policy visible in grant order
    ireqvalid_i = 1'b1; dreqvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("seq4_addr%0d", k), mreqaddr_o, (RR && (k % 2 == 1)) ? IA : DA);
      tick();
    end
    ireqvalid_i = 1'b0; dreqvalid_i = 1'b0;
    mrspvalid_i = 1'b1; mrspdata_i = 32'h0000_5EED;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("seq4_drspvalid%0d", k), drspvalid_o, (RR && (k % 2 == 1)) ? 1'b0 : 1'b1);
      chk($sformatf("seq4_irspvalid%0d", k), irspvalid_o, (RR && (k % 2 == 1)) ? 1'b1 : 1'b0);
      tick();
    end
    mrspvalid_i = 1'b0;

    // ---------------- stalled instr request keeps its grant while data becomes valid
    ireqvalid_i = 1'b1; ireqaddr_i = 32'h0000_0300; mreqready_i = 1'b0;
    #1;
    chk("lock_c0_addr", mreqaddr_o, 32'h300);
    chk("lock_c0_mreqvalid", mreqvalid_o, 1);
    tick();
    dreqvalid_i = 1'b1;
    for (int k = 1; k < 3; k++) begin
      #1;
      chk($sformatf("lock_c%0d_addr", k), mreqaddr_o, 32'h300);
      chk($sformatf("lock_c%0d_dreqready", k), dreqready_o, 0);
      tick();
    end
    mreqready_i = 1'b1;
    #1;
    chk("lock_xfer_addr", mreqaddr_o, 32'h300);
    chk("lock_xfer_ireqready", ireqready_o, 1);
    chk("lock_xfer_dreqready", dreqready_o, 0);
    tick();
    ireqvalid_i = 1'b0; ireqaddr_i = IA;
    #1;
    chk("after_lock_addr", mreqaddr_o, DA);
    chk("after_lock_dreqready", dreqready_o, 1);
    tick();
    dreqvalid_i = 1'b0;
    mrspvalid_i = 1'b1;
    #1;
    chk("lock_rsp0_irspvalid", irspvalid_o, 1);
    tick();
    #1;
    chk("lock_rsp1_drspvalid", drspvalid_o, 1);
    tick();
    mrspvalid_i = 1'b0;

    // ---------------- fill the source FIFO, fifth request blocked until a pop
    ireqvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("fill%0d_ireqready", k), ireqready_o, 1);
      tick();
    end
    #1;
    chk("full_mreqvalid", mreqvalid_o, 0);
    chk("full_ireqready", ireqready_o, 0);
    mrspvalid_i = 1'b1;
    #1;
    chk("full_pop_mrspready", mrspready_o, 1);
    chk("full_pop_mreqvalid", mreqvalid_o, 0);
    tick();
    mrspvalid_i = 1'b0;
    #1;
    chk("after_pop_mreqvalid", mreqvalid_o, 1);
    chk("after_pop_ireqready", ireqready_o, 1);
    tick();
    ireqvalid_i = 1'b0;

    // ---------------- response stalled by irspready_i=0, then async reset mid-stream
    dreqvalid_i = 1'b1; mrspvalid_i = 1'b1; irspready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("rstall%0d_mrspready", k), mrspready_o, 0);
      chk($sformatf("rstall%0d_irspvalid", k), irspvalid_o, 1);
      chk($sformatf("rstall%0d_drspvalid", k), drspvalid_o, 0);
      chk($sformatf("rstall%0d_mreqvalid", k), mreqvalid_o, 0);
      tick();
    end
    resetb_i = 1'b0;
    #1;
    chk("midrst_irspvalid", irspvalid_o, 0);
    chk("midrst_drspvalid", drspvalid_o, 0);
    chk("midrst_mrspready", mrspready_o, 0);
    mrspvalid_i = 1'b0; dreqvalid_i = 1'b0; mreqready_i = 1'b0;
    tick();
    resetb_i = 1'b1;

    // ---------------- randomized traffic against the behavioural model
    q.delete(); last_src = 1'b0; hold = 1'b0; hold_src = 1'b0;
    for (int n = 0; n < NRAND; n++) begin
      bit g, full, empty, head, e_mv, e_ir, e_dr, e_mrr, e_iv, e_dv, ixfer, dxfer, rxfer;
      clk_en_i    = ($urandom_range(0, 7) != 0);
      mreqready_i = ($urandom_range(0, 2) != 0);
      irspready_i = ($urandom_range(0, 3) != 0);
      drspready_i = ($urandom_range(0, 3) != 0);
      if (!ireqvalid_i && $urandom_range(0, 2) == 0) begin
        ireqvalid_i = 1'b1; ireqaddr_i = $urandom; ireqhpl_i = 2'($urandom_range(0, 3));
      end
      if (!dreqvalid_i && $urandom_range(0, 2) == 0) begin
        dreqvalid_i = 1'b1; dreqaddr_i = $urandom; dreqdata_i = $urandom;
        dreqsize_i = 2'($urandom_range(0, 2)); dreqdvalid_i = ($urandom_range(0, 1) == 1);
        dreqhpl_i = 2'($urandom_range(0, 3));
      end
      if (!mrspvalid_i && q.size() > 0 && $urandom_range(0, 1) == 1) begin
        mrspvalid_i = 1'b1; mrspdata_i = $urandom;
        mrsprerr_i = ($urandom_range(0, 3) == 0); mrspwerr_i = ($urandom_range(0, 3) == 0);
      end
      #1;
      full = (q.size() == 4);
      if (hold) g = hold_src;
      else if (ireqvalid_i && dreqvalid_i) g = RR ? ~last_src : 1'b1;
      else g = dreqvalid_i;
      e_mv = (g ? dreqvalid_i : ireqvalid_i) && !full;
      e_ir = ireqvalid_i && !g && mreqready_i && !full;
      e_dr = dreqvalid_i && g && mreqready_i && !full;
      chk("rnd_mreqvalid", mreqvalid_o, e_mv);
      chk("rnd_ireqready", ireqready_o, e_ir);
      chk("rnd_dreqready", dreqready_o, e_dr);
      if (e_mv) begin
        chk("rnd_addr", mreqaddr_o, g ? dreqaddr_i : ireqaddr_i);
        chk("rnd_size", mreqsize_o, g ? dreqsize_i : 2'b10);
        chk("rnd_hpl", mreqhpl_o, g ? dreqhpl_i : ireqhpl_i);
        chk("rnd_dvalid", mreqdvalid_o, g ? dreqdvalid_i : 1'b0);
        chk("rnd_wdata", mreqdata_o, g ? dreqdata_i : 32'h0);
      end
      empty = (q.size() == 0);
      head  = empty ? 1'b0 : q[0];
      e_mrr = !empty && (head ? drspready_i : irspready_i);
      e_iv  = !empty && !head && mrspvalid_i;
      e_dv  = !empty && head && mrspvalid_i;
      chk("rnd_mrspready", mrspready_o, e_mrr);
      chk("rnd_irspvalid", irspvalid_o, e_iv);
      chk("rnd_drspvalid", drspvalid_o, e_dv);
      if (mrspvalid_i) begin
        chk("rnd_irspdata", irspdata_o, mrspdata_i);
        chk("rnd_drspdata", drspdata_o, mrspdata_i);
        chk("rnd_drspwerr", drspwerr_o, mrspwerr_i);
        chk("rnd_irsprerr", irsprerr_o, mrsprerr_i);
      end
      @(posedge clk_i);
      ixfer = 1'b0; dxfer = 1'b0; rxfer = 1'b0;
      if (clk_en_i) begin
        if (mrspvalid_i && e_mrr) begin
          void'(q.pop_front());
          rxfer = 1'b1;
        end
        if (e_mv && mreqready_i) begin
          q.push_back(g);
          last_src = g;
          hold = 1'b0;
          if (g) dxfer = 1'b1; else ixfer = 1'b1;
        end else begin
          hold = e_mv;
          hold_src = g;
        end
      end
      #1;
      if (ixfer) ireqvalid_i = 1'b0;
      if (dxfer) dreqvalid_i = 1'b0;
      if (rxfer) mrspvalid_i = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
